dma_stream_sequencer: RTL and testbench

//  Per-job sequencer between the processing-system AXI DMA streams and the miner datapath.

---
 rtl/miner_dma_pkg.sv | 40 ++++
 rtl/stream_beat_counter.sv | 35 +++
 rtl/dma_stream_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_dma_stream_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_dma_pkg.sv
// Shared types and constants for the miner DMA stream sequencer.
// Contents:
//   seq_state_t   sequencer FSM states
//   sts_err_t     error flags, packed in the order they appear in status word 3
//   CTRL_*/STS_*  control and status packet layout constants
package miner_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        RUN  = 2'd2,
        STS  = 2'd3
    } seq_state_t;

    localparam int          CTRL_WORDS = 6;
    localparam int          STS_WORDS  = 4;
    localparam int          CNT_W      = 16;
    localparam logic [3:0]  CTRL_FLAG  = 4'hA;
    localparam logic [31:0] STS_FLAG   = 32'h5000_0000;

    // Status word positions.
    localparam logic [1:0] STS_IDX_FLAG  = 2'd0;
    localparam logic [1:0] STS_IDX_JOB   = 2'd1;
    localparam logic [1:0] STS_IDX_BYTES = 2'd2;
    localparam logic [1:0] STS_IDX_ERR   = 2'(STS_WORDS - 1);

    // MSB first: {err_long, err_short, err_len, err_flag} -> status word 3 bits [3:0].
    typedef struct packed {
        logic err_long;
        logic err_short;
        logic err_len;
        logic err_flag;
    } sts_err_t;

    // Word count -> byte count, zero-extended to a full status word.
    function automatic logic [31:0] words_to_bytes(input logic [CNT_W-1:0] words);
        return 32'({words, 2'b00});
    endfunction

endpackage

// File: rtl/stream_beat_counter.sv
// Saturating beat counter with a sticky "tlast seen" flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        synchronous clear (end of job)
//   beat       one transfer this cycle (tvalid & tready)
//   last       tlast of that transfer
//   count      beats seen, saturates at all-ones
//   done       set on the tlast beat, held until clr/rst
module stream_beat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat,
    input  logic             last,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            done  <= 1'b0;
        end else if (beat) begin
            if (count != '1) begin
                count <= count + CNT_W'(1);
            end
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_stream_sequencer.sv
// Per-job sequencer between the PS AXI DMA streams and the miner datapath.
// A job is: consume one MM2S control packet, pass MM2S data to the miner and
// miner results to S2MM, then emit one 4-word status packet. One job at a time.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cntrlT*                     MM2S control stream (slave)
//   mm2sT*                      MM2S data stream (slave)
//   minerInT*                   data to the miner (master)
//   minerOutT*                  results from the miner (slave)
//   s2mmT*                      S2MM data stream (master)
//   stsT*                       S2MM status stream (master)
//   jobDone                     one-cycle pulse after the status tlast handshake
//   busy                        high outside IDLE
//   dbgState                    current FSM state
// Handshake: a beat transfers only when tvalid and tready are both high at a
// rising edge; a master keeps tdata/tlast stable while tvalid is high and
// tready is low. Streams outside their phase see tready=0 / tvalid=0.
module dma_stream_sequencer
    import miner_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cntrlTdata,
    input  logic        cntrlTlast,
    input  logic        cntrlTvalid,
    output logic        cntrlTready,
    input  logic [31:0] mm2sTdata,
    input  logic        mm2sTlast,
    input  logic        mm2sTvalid,
    output logic        mm2sTready,
    output logic [31:0] minerInTdata,
    output logic        minerInTlast,
    output logic        minerInTvalid,
    input  logic        minerInTready,
    input  logic [31:0] minerOutTdata,
    input  logic        minerOutTlast,
    input  logic        minerOutTvalid,
    output logic        minerOutTready,
    output logic [31:0] s2mmTdata,
    output logic [3:0]  s2mmTkeep,
    output logic        s2mmTlast,
    output logic        s2mmTvalid,
    input  logic        s2mmTready,
    output logic [31:0] stsTdata,
    output logic [3:0]  stsTkeep,
    output logic        stsTlast,
    output logic        stsTvalid,
    input  logic        stsTready,
    output logic        jobDone,
    output logic        busy,
    output seq_state_t  dbgState
);

    seq_state_t       state;
    logic [2:0]       ctrl_idx;   // saturates at CTRL_WORDS (= "past the end")
    logic [31:0]      job_id;
    logic [CNT_W-1:0] exp_words;
    sts_err_t         err;
    logic [1:0]       sts_idx;

    logic [CNT_W-1:0] in_words, out_words;
    logic             in_done, out_done;
    logic             in_open, out_open;
    logic             in_beat, out_beat, ctrl_beat, sts_beat, sts_last_beat;
    logic             flag_bad, short_now, long_now, ctrl_err;
    logic [31:0]      sts_word;

    // RUN pass-through: each direction closes independently after its tlast.
    assign in_open  = (state == RUN) && !in_done;
    assign out_open = (state == RUN) && !out_done;

    assign mm2sTready     = in_open && minerInTready;
    assign minerInTvalid  = in_open && mm2sTvalid;
    assign minerInTdata   = in_open ? mm2sTdata : 32'h0;
    assign minerInTlast   = in_open && mm2sTlast;

    assign minerOutTready = out_open && s2mmTready;
    assign s2mmTvalid     = out_open && minerOutTvalid;
    assign s2mmTdata      = out_open ? minerOutTdata : 32'h0;
    assign s2mmTlast      = out_open && minerOutTlast;
    assign s2mmTkeep      = out_open ? 4'hF : 4'h0;

    assign in_beat       = mm2sTvalid && mm2sTready;
    assign out_beat      = s2mmTvalid && s2mmTready;
    assign ctrl_beat     = cntrlTvalid && cntrlTready;
    assign sts_beat      = stsTvalid && stsTready;
    assign sts_last_beat = sts_beat && (sts_idx == STS_IDX_ERR);

    stream_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sts_last_beat),
        .beat  (in_beat),
        .last  (mm2sTlast),
        .count (in_words),
        .done  (in_done)
    );

    stream_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sts_last_beat),
        .beat  (out_beat),
        .last  (minerOutTlast),
        .count (out_words),
        .done  (out_done)
    );

    // Error evaluation for the control beat currently on the bus; ctrl_err
    // includes flags being raised by this very beat so the tlast decision
    // sees them.
    always_comb begin
        flag_bad  = (ctrl_idx == 3'd0) ? (cntrlTdata[31:28] != CTRL_FLAG) : err.err_flag;
        short_now = cntrlTlast && (ctrl_idx < 3'(CTRL_WORDS - 1));
        long_now  = (ctrl_idx == 3'(CTRL_WORDS));
        ctrl_err  = flag_bad || short_now || long_now || err.err_short || err.err_long;
    end

    always_comb begin
        sts_word = 32'h0;
        case (sts_idx)
            STS_IDX_FLAG:  sts_word = STS_FLAG;
            STS_IDX_JOB:   sts_word = job_id;
            STS_IDX_BYTES: sts_word = words_to_bytes(out_words);
            default:       sts_word = {28'h0, err};
        endcase
    end

    assign stsTdata = stsTvalid ? sts_word : 32'h0;
    assign stsTlast = stsTvalid && (sts_idx == STS_IDX_ERR);
    assign stsTkeep = stsTvalid ? 4'hF : 4'h0;
    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctrl_idx    <= 3'd0;
            job_id      <= 32'h0;
            exp_words   <= '0;
            err         <= '0;
            sts_idx     <= 2'd0;
            cntrlTready <= 1'b0;
            stsTvalid   <= 1'b0;
            jobDone     <= 1'b0;
        end else begin
            jobDone <= 1'b0;
            case (state)
                IDLE, CTRL: begin
                    cntrlTready <= 1'b1;
                    if (ctrl_beat) begin
                        if (ctrl_idx != 3'(CTRL_WORDS)) begin
                            ctrl_idx <= ctrl_idx + 3'd1;
                        end
                        if (ctrl_idx == 3'd0) err.err_flag <= flag_bad;
                        if (ctrl_idx == 3'd1) job_id <= cntrlTdata;
                        if (ctrl_idx == 3'd2) exp_words <= cntrlTdata[CNT_W-1:0];
                        if (short_now) err.err_short <= 1'b1;
                        if (long_now)  err.err_long  <= 1'b1;
                        if (cntrlTlast) begin
                            cntrlTready <= 1'b0;
                            ctrl_idx    <= 3'd0;
                            if (ctrl_err) begin
                                state     <= STS;
                                stsTvalid <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            state <= CTRL;
                        end
                    end
                end
                RUN: begin
                    if (in_done && out_done) begin
                        state        <= STS;
                        stsTvalid    <= 1'b1;
                        err.err_len  <= (in_words != exp_words);
                    end
                end
                STS: begin
                    if (sts_beat) begin
                        if (sts_idx == STS_IDX_ERR) begin
                            state       <= IDLE;
                            stsTvalid   <= 1'b0;
                            sts_idx     <= 2'd0;
                            jobDone     <= 1'b1;
                            cntrlTready <= 1'b1;
                            err         <= '0;
                            job_id      <= 32'h0;
                            exp_words   <= '0;
                        end else begin
                            sts_idx <= sts_idx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_stream_sequencer.sv
// Self-checking bench for dma_stream_sequencer: directed jobs plus randomized
// stalled jobs, each checked against a packet-level model of the job.
module tb_dma_stream_sequencer;
    import miner_dma_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] cntrlTdata;    logic cntrlTlast, cntrlTvalid, cntrlTready;
    logic [31:0] mm2sTdata;     logic mm2sTlast, mm2sTvalid, mm2sTready;
    logic [31:0] minerInTdata;  logic minerInTlast, minerInTvalid, minerInTready;
    logic [31:0] minerOutTdata; logic minerOutTlast, minerOutTvalid, minerOutTready;
    logic [31:0] s2mmTdata;     logic [3:0] s2mmTkeep; logic s2mmTlast, s2mmTvalid, s2mmTready;
    logic [31:0] stsTdata;      logic [3:0] stsTkeep;  logic stsTlast, stsTvalid, stsTready;
    logic        jobDone, busy;
    seq_state_t  dbgState;

    dma_stream_sequencer dut (
        .clk(clk), .rst(rst),
        .cntrlTdata(cntrlTdata), .cntrlTlast(cntrlTlast), .cntrlTvalid(cntrlTvalid), .cntrlTready(cntrlTready),
        .mm2sTdata(mm2sTdata), .mm2sTlast(mm2sTlast), .mm2sTvalid(mm2sTvalid), .mm2sTready(mm2sTready),
        .minerInTdata(minerInTdata), .minerInTlast(minerInTlast), .minerInTvalid(minerInTvalid),
        .minerInTready(minerInTready),
        .minerOutTdata(minerOutTdata), .minerOutTlast(minerOutTlast), .minerOutTvalid(minerOutTvalid),
        .minerOutTready(minerOutTready),
        .s2mmTdata(s2mmTdata), .s2mmTkeep(s2mmTkeep), .s2mmTlast(s2mmTlast), .s2mmTvalid(s2mmTvalid),
        .s2mmTready(s2mmTready),
        .stsTdata(stsTdata), .stsTkeep(stsTkeep), .stsTlast(stsTlast), .stsTvalid(stsTvalid),
        .stsTready(stsTready),
        .jobDone(jobDone), .busy(busy), .dbgState(dbgState)
    );

    // ---------------- job description and capture ----------------
    logic [31:0] ctrl_q[$], in_q[$], out_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] min_q[$], s2mm_q[$], sts_q[$];
    int min_last_at, s2mm_last_at, sts_last_at, sts_last_cnt;
    int job_done_cycles, keep_bad, same_last_cycles, mm2s_rdy_seen;
    int tests_run = 0, tests_failed = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (minerInTvalid && minerInTready) begin
                min_q.push_back(minerInTdata);
                if (minerInTlast) min_last_at = min_q.size();
            end
            if (s2mmTvalid && s2mmTready) begin
                s2mm_q.push_back(s2mmTdata);
                if (s2mmTlast) s2mm_last_at = s2mm_q.size();
                if (s2mmTkeep !== 4'hF) keep_bad++;
            end
            if (stsTvalid && stsTready) begin
                sts_q.push_back(stsTdata);
                if (stsTlast) begin
                    sts_last_at = sts_q.size();
                    sts_last_cnt++;
                end
                if (stsTkeep !== 4'hF) keep_bad++;
            end
            if (minerInTvalid && minerInTready && minerInTlast && s2mmTvalid && s2mmTready && s2mmTlast)
                same_last_cycles++;
            if (jobDone) job_done_cycles++;
            if (mm2sTready) mm2s_rdy_seen++;
        end
    end

    task automatic clear_capture();
        min_q.delete(); s2mm_q.delete(); sts_q.delete();
        min_last_at = 0; s2mm_last_at = 0; sts_last_at = 0; sts_last_cnt = 0;
        job_done_cycles = 0; keep_bad = 0; same_last_cycles = 0; mm2s_rdy_seen = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        cntrlTvalid = 0; cntrlTlast = 0; mm2sTvalid = 0; mm2sTlast = 0;
        minerOutTvalid = 0; minerOutTlast = 0;
        minerInTready = 1; s2mmTready = 1; stsTready = 1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fill_data(input int n_in, input int n_out);
        in_q.delete(); out_q.delete();
        for (int i = 0; i < n_in; i++)  in_q.push_back($urandom);
        for (int i = 0; i < n_out; i++) out_q.push_back($urandom);
    endtask

    // Offers all three source streams from the start; returns when jobDone is
    // seen, when rst_after mm2s beats have been accepted, or on timeout.
    task automatic run_job(input bit stall, input int rst_after, output bit finished);
        int ci, ii, oi, cyc;
        bit hc, hi, ho;
        ci = 0; ii = 0; oi = 0; cyc = 0; finished = 0;
        clear_capture();
        while (!finished && cyc < 3000) begin
            if (!cntrlTvalid && ci < ctrl_q.size() && (!stall || $urandom_range(0, 2) != 0)) begin
                cntrlTvalid = 1; cntrlTdata = ctrl_q[ci]; cntrlTlast = (ci == ctrl_q.size() - 1);
            end
            if (!mm2sTvalid && ii < in_q.size() && (!stall || $urandom_range(0, 2) != 0)) begin
                mm2sTvalid = 1; mm2sTdata = in_q[ii]; mm2sTlast = (ii == in_q.size() - 1);
            end
            if (!minerOutTvalid && oi < out_q.size() && (!stall || $urandom_range(0, 2) != 0)) begin
                minerOutTvalid = 1; minerOutTdata = out_q[oi]; minerOutTlast = (oi == out_q.size() - 1);
            end
            minerInTready = !stall || ($urandom_range(0, 2) != 0);
            s2mmTready    = !stall || ($urandom_range(0, 2) != 0);
            stsTready     = !stall || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            hc = cntrlTvalid && cntrlTready;
            hi = mm2sTvalid && mm2sTready;
            ho = minerOutTvalid && minerOutTready;
            if (jobDone) finished = 1;
            @(posedge clk); #1;
            cyc++;
            if (hc) begin ci++; cntrlTvalid = 0; cntrlTlast = 0; end
            if (hi) begin ii++; mm2sTvalid = 0; mm2sTlast = 0; end
            if (ho) begin oi++; minerOutTvalid = 0; minerOutTlast = 0; end
            if (rst_after >= 0 && ii >= rst_after) break;
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    task automatic check_job(input string tag);
        int n;
        logic [31:0] w0, w2;
        bit flag_bad, short_p, long_p, run_ok, len_err;
        logic [31:0] job;
        logic [15:0] expw;
        int bytes;
        n  = ctrl_q.size();
        w0 = ctrl_q[0];
        w2 = (n > 2) ? ctrl_q[2] : 32'h0;
        flag_bad = (w0[31:28] != 4'hA);
        short_p  = (n < 6);
        long_p   = (n > 6);
        run_ok   = !(flag_bad || short_p || long_p);
        job      = (n > 1) ? ctrl_q[1] : 32'h0;
        expw     = w2[15:0];
        len_err  = run_ok && (in_q.size() != int'(expw));
        bytes    = run_ok ? out_q.size() * 4 : 0;

        exp_q.delete();
        if (run_ok) foreach (in_q[i]) exp_q.push_back(in_q[i]);
        check($sformatf("%s_min_n", tag), 32'(min_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_min%0d", tag, i), (i < min_q.size()) ? min_q[i] : 32'hxxxx_xxxx, exp_q[i]);
        check($sformatf("%s_min_last", tag), 32'(min_last_at), 32'(exp_q.size()));

        exp_q.delete();
        if (run_ok) foreach (out_q[i]) exp_q.push_back(out_q[i]);
        check($sformatf("%s_s2mm_n", tag), 32'(s2mm_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_s2mm%0d", tag, i), (i < s2mm_q.size()) ? s2mm_q[i] : 32'hxxxx_xxxx, exp_q[i]);
        check($sformatf("%s_s2mm_last", tag), 32'(s2mm_last_at), 32'(exp_q.size()));
        if (!run_ok) check($sformatf("%s_mm2s_rdy", tag), 32'(mm2s_rdy_seen), 32'd0);

        exp_q.delete();
        exp_q.push_back(32'h5000_0000);
        exp_q.push_back(job);
        exp_q.push_back(32'(bytes));
        exp_q.push_back({28'h0, long_p, short_p, len_err, flag_bad});
        check($sformatf("%s_sts_n", tag), 32'(sts_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_sts_w%0d", tag, i), (i < sts_q.size()) ? sts_q[i] : 32'hxxxx_xxxx, exp_q[i]);
        check($sformatf("%s_sts_last_at", tag), 32'(sts_last_at), 32'd4);
        check($sformatf("%s_sts_last_cnt", tag), 32'(sts_last_cnt), 32'd1);
        check($sformatf("%s_job_done", tag), 32'(job_done_cycles), 32'd1);
        check($sformatf("%s_keep", tag), 32'(keep_bad), 32'd0);
    endtask

    // ---------------- directed steps ----------------
    initial begin
        bit fin;
        logic [27:0] lo;
        rst = 1;
        cntrlTdata = 0; cntrlTlast = 0; cntrlTvalid = 0;
        mm2sTdata = 0; mm2sTlast = 0; mm2sTvalid = 0;
        minerOutTdata = 0; minerOutTlast = 0; minerOutTvalid = 0;
        minerInTready = 1; s2mmTready = 1; stsTready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({cntrlTready, mm2sTready, minerInTvalid, minerInTlast, minerOutTready,
                                    s2mmTvalid, s2mmTlast, stsTvalid, stsTlast, jobDone, busy}), 32'd0);
        check("reset_state", 32'(dbgState), 32'(IDLE));
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(negedge clk);
        check("idle_cntrl_ready", 32'(cntrlTready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 1: clean job, 4 in / 2 out
        ctrl_q = '{32'hA000_0000, 32'd7, 32'd4, 32'd0, 32'd0, 32'd0};
        fill_data(4, 2);
        run_job(0, -1, fin); check("t1_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t1");

        // 2: one extra input word -> length error
        fill_data(5, 2);
        run_job(0, -1, fin); check("t2_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t2");

        // 3: bad control flag, RUN skipped
        ctrl_q = '{32'h3000_0000, 32'h0000_0033, 32'd4, 32'd0, 32'd0, 32'd0};
        fill_data(4, 2);
        run_job(0, -1, fin); check("t3_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t3");

        // 4: short and long control packets
        ctrl_q = '{32'hA000_0000, 32'd9, 32'd4, 32'd0};
        fill_data(4, 2);
        run_job(0, -1, fin); check("t4s_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t4s");
        ctrl_q = '{32'hA000_0000, 32'd10, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        run_job(0, -1, fin); check("t4l_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t4l");

        // 5a: both tlasts in the same cycle
        ctrl_q = '{32'hA000_0000, 32'd11, 32'd3, 32'd0, 32'd0, 32'd0};
        fill_data(3, 3);
        run_job(0, -1, fin); check("t5a_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t5a");
        check("t5a_same_last", 32'(same_last_cycles), 32'd1);

        // 5b: random stalls on every stream, random lengths
        for (int j = 0; j < 6; j++) begin
            int ew;
            ew = $urandom_range(1, 6);
            lo = 28'($urandom);
            ctrl_q.delete();
            ctrl_q.push_back({4'hA, lo});
            ctrl_q.push_back($urandom);
            ctrl_q.push_back(32'(ew));
            for (int k = 0; k < 3; k++) ctrl_q.push_back($urandom);
            fill_data(ew + int'($urandom_range(0, 1)), $urandom_range(1, 6));
            run_job(1, -1, fin); check($sformatf("t5b%0d_timeout", j), 32'(fin), 32'd1);
            idle(4); check_job($sformatf("t5b%0d", j));
        end

        // 6: reset in the middle of RUN, then a clean job
        ctrl_q = '{32'hA000_0000, 32'd21, 32'd4, 32'd0, 32'd0, 32'd0};
        fill_data(4, 2);
        run_job(0, 2, fin);
        check("t6_pre_min_n", 32'(min_q.size()), 32'd2);
        cntrlTvalid = 0; mm2sTvalid = 0; minerOutTvalid = 0;
        cntrlTlast = 0; mm2sTlast = 0; minerOutTlast = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("t6_reset_outputs", 32'({cntrlTready, mm2sTready, minerInTvalid, minerInTlast, minerOutTready,
                                       s2mmTvalid, s2mmTlast, stsTvalid, stsTlast, jobDone, busy}), 32'd0);
        check("t6_reset_state", 32'(dbgState), 32'(IDLE));
        check("t6_no_status", 32'(sts_q.size()), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle(2);
        ctrl_q = '{32'hA000_0000, 32'd22, 32'd4, 32'd0, 32'd0, 32'd0};
        fill_data(4, 2);
        run_job(0, -1, fin); check("t6_timeout", 32'(fin), 32'd1);
        idle(3); check_job("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
